// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle memory access sequencer between the CPU control unit and the
// shared instruction/data memory. It accepts one request at a time and holds the address and
// write data stable. It counts a fixed read/write latency, registers read data, and then
// pulses done for one cycle.
//
// Optional feature: define MEM_ACCESS_ALIGN_CHK_EN to enable alignment checking. With it, a
// request with addr[1:0] != 0 completes next cycle with done=1, err=1 and no memory access.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   access request (sampled in IDLE and DONE only)
//   we         in   1 = write, 0 = read (sampled with req)
//   addr       in   byte address (sampled with req)
//   wdata      in   write data (sampled with req)
//   busy       out  high in ACCESS and WAIT
//   done       out  one-cycle completion pulse
//   rdata      out  registered read data
//   err        out  alignment error, qualified by done
//   mem_en     out  memory enable (ACCESS only)
//   mem_we     out  memory write enable (ACCESS only)
//   mem_addr   out  latched address
//   mem_wdata  out  latched write data
//   mem_rdata  in   memory read data
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] RdLatC = 4'(RD_LAT);
  localparam logic [3:0] WrLatC = 4'(WR_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  logic                err_q, err_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      // DONE accepts a new request directly so back-to-back accesses have no IDLE bubble.
      StIdle, StDone: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = StAccess;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
          err_d   = 1'b0;
          if (addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        cnt_d   = we_q ? WrLatC : RdLatC;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
          if (!we_q) rdata_d = mem_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q == StAccess) || (state_q == StWait);
  assign done      = (state_q == StDone);
  assign rdata     = rdata_q;
  assign mem_en    = (state_q == StAccess);
  assign mem_we    = (state_q == StAccess) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
  assign err       = (state_q == StDone) && err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int unsigned RdLat = 2;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .RD_LAT(RdLat),
    .WR_LAT(1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: 16 words, word index = addr[5:2]. Read data is valid only in the cycle
  // RdLat after mem_en is sampled; any other cycle shows a poison value.
  logic [31:0] mem [16];
  int          lat_cnt;
  logic [3:0]  rd_idx;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
      mem[4]  <= 32'hDEADBEEF;
      lat_cnt <= 0;
      rd_idx  <= 4'd0;
    end else begin
      if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      if (mem_en && !mem_we) begin
        lat_cnt <= RdLat;
        rd_idx  <= mem_addr[5:2];
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  assign mem_rdata = (lat_cnt == 1) ? mem[rd_idx] : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge and observe until done (bounded).
  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int done_cyc, output int en_cnt, output int busy_cnt,
                         output logic we_seen, output logic err_seen, output logic addr_ok);
    req = 1'b1; we = w; addr = a; wdata = d;
    done_cyc = -1; en_cnt = 0; busy_cnt = 0; we_seen = 1'b0; err_seen = 1'b0; addr_ok = 1'b1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge clock);
      req = 1'b0;
      if (mem_en) begin en_cnt++; we_seen = mem_we; end
      if (busy) busy_cnt++;
      if ((busy || done) && mem_addr !== a) addr_ok = 1'b0;
      if (done) begin done_cyc = c; err_seen = err; end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   dc, ec, bc;
    logic ws, es, ao;
    int   en_cyc [2];
    int   dn_cyc [2];
    int   ne, nd;

    vecs[0] = '{1'b0, 32'h10, 32'h0,        4, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 32'h20, 32'h12345678, 3, 32'hDEADBEEF, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h20, 32'h0,        4, 32'h12345678, 1'b0, 1};
    vecs[3] = '{1'b1, 32'h14, 32'hCAFEF00D, 3, 32'h12345678, 1'b0, 1};
    vecs[4] = '{1'b0, 32'h14, 32'h0,        4, 32'hCAFEF00D, 1'b0, 1};
`ifdef MEM_ACCESS_ALIGN_CHK_EN
    vecs[5] = '{1'b0, 32'h13, 32'h0,        1, 32'hCAFEF00D, 1'b1, 0};
`else
    vecs[5] = '{1'b0, 32'h13, 32'h0,        4, 32'hDEADBEEF, 1'b0, 1};
`endif

    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clock);
    check("reset_busy",   32'(busy),   32'h0);
    check("reset_done",   32'(done),   32'h0);
    check("reset_err",    32'(err),    32'h0);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_rdata",  rdata,       32'h0);
    check("reset_maddr",  mem_addr,    32'h0);
    check("reset_mwdata", mem_wdata,   32'h0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, dc, ec, bc, ws, es, ao);
      check($sformatf("v%0d_latency", i), 32'(dc), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(es), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_mem_en_cnt", i), 32'(ec), 32'(vecs[i].exp_en));
      check($sformatf("v%0d_busy_cnt", i), 32'(bc), 32'(vecs[i].exp_lat - 1));
      check($sformatf("v%0d_mem_we", i), 32'(ws), 32'(vecs[i].we & (vecs[i].exp_en != 0)));
      check($sformatf("v%0d_addr_stable", i), 32'(ao), 32'h1);
      @(negedge clock);
    end
    check("mem_word_20", mem[8], 32'h12345678);
    check("mem_word_14", mem[5], 32'hCAFEF00D);

    // Reset during WAIT aborts the access and clears rdata.
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clock); req = 1'b0;
    @(negedge clock);
    check("abort_in_wait", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_busy",   32'(busy),   32'h0);
    check("abort_done",   32'(done),   32'h0);
    check("abort_mem_en", 32'(mem_en), 32'h0);
    check("abort_rdata",  rdata,       32'h0);
    check("abort_maddr",  mem_addr,    32'h0);
    @(negedge clock);
    reset = 1'b1;
    nd = 0; ne = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (done) nd++;
      if (busy) ne++;
    end
    check("abort_no_done", 32'(nd), 32'h0);
    check("abort_no_busy", 32'(ne), 32'h0);

    // Back-to-back: read then write with req held through DONE.
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0;
    ne = 0; nd = 0; en_cyc = '{-1, -1}; dn_cyc = '{-1, -1};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (mem_en) begin
        if (ne < 2) en_cyc[ne] = c;
        ne++;
        if (mem_we) req = 1'b0;
      end
      if (done) begin
        if (nd < 2) dn_cyc[nd] = c;
        nd++;
        if (nd == 1) begin we = 1'b1; addr = 32'h24; wdata = 32'h55AA55AA; end
      end
    end
    check("b2b_en_count",   32'(ne),        32'd2);
    check("b2b_done_count", 32'(nd),        32'd2);
    check("b2b_en0_cyc",    32'(en_cyc[0]), 32'd1);
    check("b2b_done0_cyc",  32'(dn_cyc[0]), 32'd4);
    check("b2b_en1_cyc",    32'(en_cyc[1]), 32'd5);
    check("b2b_done1_cyc",  32'(dn_cyc[1]), 32'd7);
    check("b2b_mem_24",     mem[9],         32'h55AA55AA);
    check("b2b_rdata",      rdata,          32'hDEADBEEF);

    // req pulsed during WAIT is ignored.
    req = 1'b1; we = 1'b0; addr = 32'h20; wdata = '0;
    ne = 0; nd = 0; dc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      req = (c == 2);
      if (mem_en) ne++;
      if (done) begin nd++; dc = c; end
    end
    check("ign_en_count",   32'(ne), 32'd1);
    check("ign_done_count", 32'(nd), 32'd1);
    check("ign_done_cyc",   32'(dc), 32'd4);
    check("ign_rdata",      rdata,   32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
